// File: rtl/dds_freq_meter.sv
// Frequency meter for an 8-bit DDS sample stream: counts hysteresis-qualified
// rising mid-scale crossings over a gate window and divides them into a tuning word.
module dds_freq_meter #(
  parameter int unsigned GATE_CYCLES = 1_000_000,
  parameter int unsigned HYST        = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  data_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] freq_o,
  output logic [15:0] count_o,
  output logic        err_o
);

  localparam logic [7:0]  ARM_LVL  = 8'(128 - HYST);
  localparam logic [7:0]  FIRE_LVL = 8'(128 + HYST);
  localparam logic [31:0] G_LAST   = 32'(GATE_CYCLES - 1);
  localparam logic [15:0] N_MAX    = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FIRST, S_GATE, S_DIVIDE, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] g_q, g_d;
  logic [15:0] n_q, n_d;
  logic [31:0] t_first_q, t_first_d;
  logic [31:0] t_last_q, t_last_d;
  logic        armed_q, armed_d;
  logic        err_q, err_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] div_q, div_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  bit_q, bit_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [31:0] freq_q, freq_d;
  logic [15:0] count_q, count_d;
  logic        res_err_q, res_err_d;

  logic        fire_c;
  logic        last_c;
  logic [33:0] rem_sh_c;

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    n_d       = n_q;
    t_first_d = t_first_q;
    t_last_d  = t_last_q;
    armed_d   = armed_q;
    err_d     = err_q;
    rem_d     = rem_q;
    div_d     = div_q;
    quo_d     = quo_q;
    bit_d     = bit_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    freq_d    = freq_q;
    count_d   = count_q;
    res_err_d = res_err_q;

    fire_c   = armed_q && (data_i >= FIRE_LVL);
    last_c   = (g_q == G_LAST);
    rem_sh_c = {rem_q, 1'b0};

    // Detector: a sample at or below the arm level re-arms even on a firing edge
    if (state_q == S_WAIT_FIRST || state_q == S_GATE) begin
      g_d = g_q + 32'd1;
      if (data_i <= ARM_LVL) armed_d = 1'b1;
      else if (fire_c)       armed_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_WAIT_FIRST;
          g_d       = '0;
          n_d       = '0;
          t_first_d = '0;
          t_last_d  = '0;
          armed_d   = 1'b0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_WAIT_FIRST: begin
        if (fire_c) begin
          t_first_d = g_q;
          n_d       = 16'd1;
          state_d   = S_GATE;
        end
        if (last_c) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_GATE: begin
        if (fire_c && (n_q != N_MAX)) begin
          n_d      = n_q + 16'd1;
          t_last_d = g_q;
        end
        if (last_c) begin
          if (n_d >= 16'd2) begin
            state_d = S_DIVIDE;
            div_d   = t_last_d - t_first_q;
            rem_d   = {17'd0, 16'(n_d - 16'd1)};
            quo_d   = '0;
            bit_d   = '0;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DIVIDE: begin
        // Restoring division, one quotient bit per cycle, MSB first
        if (rem_sh_c >= {2'b00, div_q}) begin
          rem_d = 33'(rem_sh_c - {2'b00, div_q});
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = 33'(rem_sh_c);
          quo_d = {quo_q[30:0], 1'b0};
        end
        bit_d = 5'(bit_q + 5'd1);
        if (bit_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        freq_d    = err_q ? 32'd0 : quo_q;
        count_d   = n_q;
        res_err_d = err_q;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      n_q       <= '0;
      t_first_q <= '0;
      t_last_q  <= '0;
      armed_q   <= 1'b0;
      err_q     <= 1'b0;
      rem_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      freq_q    <= '0;
      count_q   <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      n_q       <= n_d;
      t_first_q <= t_first_d;
      t_last_q  <= t_last_d;
      armed_q   <= armed_d;
      err_q     <= err_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      quo_q     <= quo_d;
      bit_q     <= bit_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      freq_q    <= freq_d;
      count_q   <= count_d;
      res_err_q <= res_err_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign freq_o  = freq_q;
  assign count_o = count_q;
  assign err_o   = res_err_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Bench for dds_freq_meter: fixed pattern table, randomized patterns against an
// array-scan reference model, plus reset and restart corner sequences.
module tb_dds_freq_meter;

  localparam int unsigned G    = 100;
  localparam int unsigned HYST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        start;
  logic        busy, valid, err;
  logic [31:0] freq;
  logic [15:0] count;

  int tests = 0;
  int fails = 0;

  logic [7:0] samp [G];

  typedef struct {
    int          kind;
    string       name;
    logic [15:0] cnt;
    logic [31:0] frq;
    bit          er;
  } vec_t;

  vec_t vecs [10];

  dds_freq_meter #(.GATE_CYCLES(G), .HYST(HYST)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .start_i(start),
    .busy_o(busy), .valid_o(valid), .freq_o(freq), .count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input string n, input logic [15:0] c,
                              input logic [31:0] f, input bit e);
    vec_t v;
    v.kind = k; v.name = n; v.cnt = c; v.frq = f; v.er = e;
    return v;
  endfunction

  task automatic fill(input int kind);
    for (int g = 0; g < int'(G); g++) begin
      case (kind)
        0: samp[g] = (g % 2 == 1) ? 8'd255 : 8'd0;
        1: samp[g] = 8'd128;
        2: samp[g] = 8'(125 + $urandom_range(0, 6));
        3: samp[g] = (g < 10) ? 8'd0 : 8'd255;
        4: samp[g] = ((g / 5) % 2 == 1) ? 8'd255 : 8'd0;
        5: samp[g] = ((g / 4) % 2 == 1) ? 8'd255 : 8'd0;
        6: samp[g] = (g == 99) ? 8'd255 : 8'd0;
        7: samp[g] = ((g >= 10 && g < 50) || g == 99) ? 8'd255 : 8'd0;
        8: samp[g] = (g % 2 == 1) ? 8'd132 : 8'd124;
        default: samp[g] = (g % 2 == 1) ? 8'd131 : 8'd125;
      endcase
    end
  endtask

  // Scan the window sample by sample with the crossing rules, then divide with 64-bit math
  task automatic model(output logic [15:0] n_o, output logic [31:0] q_o, output bit e_o);
    int unsigned n = 0;
    longint unsigned tf = 0, tl = 0;
    bit armed = 0;
    bit ev;
    logic [63:0] num;
    for (int g = 0; g < int'(G); g++) begin
      ev = armed && (int'(samp[g]) >= 128 + int'(HYST));
      if (int'(samp[g]) <= 128 - int'(HYST)) armed = 1;
      else if (ev) armed = 0;
      if (ev) begin
        if (n == 0) begin tf = longint'(g); n = 1; end
        else if (n < 65535) begin n++; tl = longint'(g); end
      end
    end
    n_o = 16'(n);
    e_o = (n < 2);
    num = 64'(n - 1) << 32;
    q_o = e_o ? 32'd0 : 32'(num / (tl - tf));
  endtask

  task automatic run_meas(input string name, input logic [15:0] ecnt, input logic [31:0] efreq,
                          input bit eerr, input bit repulse);
    int cyc;
    int elat;
    elat = eerr ? int'(G) + 1 : int'(G) + 33;
    @(posedge clk); #1; start = 1'b1; data = samp[0];
    @(posedge clk); #1; start = 1'b0; cyc = 0;
    chk({name, "/busy_start"}, 64'(busy), 64'd1);
    for (int g = 0; g < int'(G); g++) begin
      @(posedge clk); #1; cyc++;
      data  = (g + 1 < int'(G)) ? samp[g + 1] : 8'd128;
      start = repulse && (g == 50);
    end
    start = 1'b0;
    while (!valid && cyc < int'(G) + 60) begin
      @(posedge clk); #1; cyc++;
      start = repulse && (cyc == int'(G) + 10);
    end
    start = 1'b0;
    chk({name, "/latency"}, 64'(cyc), 64'(elat));
    chk({name, "/valid"}, 64'(valid), 64'd1);
    chk({name, "/freq"}, 64'(freq), 64'(efreq));
    chk({name, "/count"}, 64'(count), 64'(ecnt));
    chk({name, "/err"}, 64'(err), 64'(eerr));
    chk({name, "/busy_end"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({name, "/valid_drop"}, 64'(valid), 64'd0);
    chk({name, "/freq_hold"}, 64'(freq), 64'(efreq));
    repeat (4) @(posedge clk);
    #1;
    chk({name, "/idle_after"}, 64'({busy, valid}), 64'd0);
  endtask

  task automatic reset_mid(input string name, input int at_cyc);
    int pulses = 0;
    fill(0);
    @(posedge clk); #1; start = 1'b1; data = samp[0];
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= at_cyc; c++) begin
      @(posedge clk); #1;
      data = (c < int'(G)) ? samp[c] : 8'd128;
    end
    #2; rst = 1'b1; #1;
    chk({name, "/freq"}, 64'(freq), 64'd0);
    chk({name, "/count"}, 64'(count), 64'd0);
    chk({name, "/flags"}, 64'({busy, valid, err}), 64'd0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < int'(G) + 40; c++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    chk({name, "/no_valid"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    logic [15:0] mn;
    logic [31:0] mq;
    bit          me;
    int          mode;
    int unsigned half, ph;

    vecs[0] = mk(0, "alt_0_255",   16'd50, 32'h8000_0000, 1'b0);
    vecs[1] = mk(1, "const_128",   16'd0,  32'd0,         1'b1);
    vecs[2] = mk(2, "noise_pm3",   16'd0,  32'd0,         1'b1);
    vecs[3] = mk(3, "single_step", 16'd1,  32'd0,         1'b1);
    vecs[4] = mk(4, "square_10",   16'd10, 32'(64'h1_0000_0000 / 10), 1'b0);
    vecs[5] = mk(5, "square_8",    16'd12, 32'h2000_0000, 1'b0);
    vecs[6] = mk(6, "first_on_last", 16'd1, 32'd0,        1'b1);
    vecs[7] = mk(7, "last_edge_ev", 16'd2, 32'(64'h1_0000_0000 / 89), 1'b0);
    vecs[8] = mk(8, "thresh_124_132", 16'd50, 32'h8000_0000, 1'b0);
    vecs[9] = mk(9, "inside_125_131", 16'd0, 32'd0,       1'b1);

    rst = 1'b1; start = 1'b0; data = 8'd128;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/freq", 64'(freq), 64'd0);
    chk("reset/count", 64'(count), 64'd0);
    chk("reset/flags", 64'({busy, valid, err}), 64'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      fill(vecs[i].kind);
      run_meas(vecs[i].name, vecs[i].cnt, vecs[i].frq, vecs[i].er, 1'b0);
    end

    fill(0);
    run_meas("restart_ignored", 16'd50, 32'h8000_0000, 1'b0, 1'b1);
    reset_mid("rst_mid_gate", 50);
    fill(4);
    run_meas("after_rst_gate", 16'd10, 32'(64'h1_0000_0000 / 10), 1'b0, 1'b0);
    reset_mid("rst_mid_divide", int'(G) + 15);
    fill(0);
    run_meas("after_rst_div", 16'd50, 32'h8000_0000, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      mode = i % 3;
      half = $urandom_range(2, 12);
      ph   = $urandom_range(0, 23);
      for (int g = 0; g < int'(G); g++) begin
        case (mode)
          0: samp[g] = 8'($urandom_range(0, 255));
          1: samp[g] = (((g + int'(ph)) / int'(half)) % 2 == 1) ?
                       8'(200 + $urandom_range(0, 40)) : 8'(15 + $urandom_range(0, 40));
          default: samp[g] = 8'(118 + $urandom_range(0, 20));
        endcase
      end
      model(mn, mq, me);
      run_meas($sformatf("rand%0d", i), mn, mq, me, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
